// File: rtl/sort_stage_sequencer.sv
// Step sequencer for a 2**LOG2N-lane bitonic sorting network: walks (stage, substage) pairs under valid/ready.
// Optional accepted-step counter on o_step_cnt when SORT_SEQ_STEPCNT_EN is defined.
module sort_stage_sequencer #(
   parameter int unsigned LOG2N = 4,
   parameter int unsigned STW   = 4,
   parameter int unsigned CNTW  = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic            i_abort,
   input  logic            i_step_rdy,
   output logic            o_step_vld,
   output logic [STW-1:0]  o_stage,
   output logic [STW-1:0]  o_sub,
   output logic            o_last,
   output logic            o_busy,
   output logic            o_done
`ifdef SORT_SEQ_STEPCNT_EN
   ,
   output logic [CNTW-1:0] o_step_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [STW-1:0] LAST_STAGE = STW'(LOG2N - 1);

   state_t         state_q, state_d;
   logic [STW-1:0] stage_q, stage_d;
   logic [STW-1:0] sub_q,   sub_d;
   logic           accept;

   assign accept = (state_q == RUN) && i_step_rdy;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         stage_q <= '0;
         sub_q   <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         sub_q   <= sub_d;
      end
   end

   // Abort overrides everything, including a start or a handshake in the same cycle.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      sub_d   = sub_q;
      if (i_abort) begin
         state_d = IDLE;
         stage_d = '0;
         sub_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_start) begin
                  state_d = RUN;
                  stage_d = '0;
                  sub_d   = '0;
               end
            end
            RUN: begin
               if (i_step_rdy) begin
                  if (sub_q != '0) begin
                     sub_d = sub_q - 1'b1;
                  end else if (stage_q != LAST_STAGE) begin
                     stage_d = stage_q + 1'b1;
                     sub_d   = stage_q + 1'b1;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

`ifdef SORT_SEQ_STEPCNT_EN
   logic [CNTW-1:0] cnt_q, cnt_d;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (i_abort) begin
         cnt_d = '0;
      end else if ((state_q == IDLE) && i_start) begin
         cnt_d = '0;
      end else if (accept) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign o_step_cnt = cnt_q;
`endif

   assign o_step_vld = (state_q == RUN);
   assign o_stage    = stage_q;
   assign o_sub      = sub_q;
   assign o_last     = o_step_vld && (stage_q == LAST_STAGE) && (sub_q == '0);
   assign o_busy     = (state_q != IDLE);
   assign o_done     = (state_q == DONE);

endmodule
